// File: rtl/fc_batch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fc_batch_sequencer_if
//   Bundles the host-side load/run/readback signals and the fc_layer-side
//   signals of fc_batch_sequencer into one interface.
//
//   Modports
//     slave  : the sequencer's view (drives ld_ready, busy, batch_done, err,
//              fc_start, fc_data_in, rd_data).
//     master : the environment's view (host/DMA plus the fc_layer engine).
//
//   Handshake semantics: a load byte transfers on a cycle where
//   ld_valid && ld_ready.  ld_valid may be raised at any time and carries no
//   obligation to hold.  A run pulse is accepted only while ld_ready is high
//   (sequencer idle); pulses seen at any other time are dropped.
// ---------------------------------------------------------------------------
interface fc_batch_sequencer_if #(
    parameter int NUM_NEURONS = 10,
    parameter int MAX_CASES   = 8
);
    localparam int CW = $clog2(MAX_CASES + 1);
    localparam int RW = $clog2(MAX_CASES * NUM_NEURONS);

    // host load / control
    logic                 ld_valid;
    logic signed [7:0]    ld_data;
    logic                 ld_ready;
    logic                 run;
    logic [CW-1:0]        num_cases;
    logic                 busy;
    logic                 batch_done;
    logic                 err;
    // fc_layer side
    logic                 fc_start;
    logic signed [7:0]    fc_data_in;
    logic                 fc_input_req;
    logic                 fc_out_valid;
    logic signed [7:0]    fc_data_out;
    logic                 fc_done;
    // result readback
    logic [RW-1:0]        rd_addr;
    logic signed [7:0]    rd_data;

    modport slave (
        input  ld_valid, ld_data, run, num_cases,
        input  fc_input_req, fc_out_valid, fc_data_out, fc_done, rd_addr,
        output ld_ready, busy, batch_done, err, fc_start, fc_data_in, rd_data
    );

    modport master (
        output ld_valid, ld_data, run, num_cases,
        output fc_input_req, fc_out_valid, fc_data_out, fc_done, rd_addr,
        input  ld_ready, busy, batch_done, err, fc_start, fc_data_in, rd_data
    );
endinterface

// File: rtl/fc_batch_sequencer.sv
// ---------------------------------------------------------------------------
// fc_batch_sequencer
//   Runs the fc_layer engine once per input vector of a batch.  The host
//   fills an input buffer while idle; a run pulse then starts one fc_layer
//   pass per vector, feeds that vector repeatedly on fc_input_req, and
//   stores every fc_out_valid byte in a result buffer readable at any time.
//
//   Ports
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset
//     bus       : fc_batch_sequencer_if.slave (load, run, fc_layer, readback)
//     dbg_state : current FSM state (IDLE=0 START=1 RUN=2 GAP=3 FIN=4)
// ---------------------------------------------------------------------------
module fc_batch_sequencer #(
    parameter int NUM_NEURONS = 10,
    parameter int NUM_INPUTS  = 4,
    parameter int MAX_CASES   = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    fc_batch_sequencer_if.slave bus,
    output logic [2:0]          dbg_state
);
    localparam int IN_DEPTH  = MAX_CASES * NUM_INPUTS;
    localparam int RES_DEPTH = MAX_CASES * NUM_NEURONS;
    localparam int CW = $clog2(MAX_CASES + 1);
    localparam int RW = $clog2(RES_DEPTH);
    localparam int IW = $clog2(IN_DEPTH);
    localparam int PW = $clog2(NUM_INPUTS + 1);
    localparam int OW = $clog2(NUM_NEURONS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [CW-1:0] MAX_C    = CW'(MAX_CASES);
    localparam logic [IW-1:0] LD_LAST  = IW'(IN_DEPTH - 1);
    localparam logic [PW-1:0] IN_LAST  = PW'(NUM_INPUTS - 1);
    localparam logic [OW-1:0] NN_C     = OW'(NUM_NEURONS);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_GAP   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t state, state_nx;

    logic signed [7:0] in_buf  [IN_DEPTH];
    logic signed [7:0] res_buf [RES_DEPTH];

    logic [CW-1:0] n_q;
    logic [CW-1:0] case_idx;
    logic [IW-1:0] ld_ptr;
    logic [PW-1:0] in_ptr;
    logic [OW-1:0] out_cnt;
    logic [GW-1:0] gap_cnt;
    logic          busy_q, batch_done_q, err_q, fc_start_q;
    logic signed [7:0] fc_data_in_q, rd_data_q;

    logic          run_acc, ld_acc, cap_ok, drop, count_bad, rd_in_range;
    logic [OW-1:0] out_cnt_nx;
    logic [CW-1:0] case_nx;
    logic [IW-1:0] in_addr;
    logic [RW-1:0] res_addr;

    assign run_acc  = (state == S_IDLE) && bus.run;
    assign ld_acc   = (state == S_IDLE) && bus.ld_valid;
    assign cap_ok   = bus.fc_out_valid && (state == S_RUN) && (out_cnt < NN_C);
    // Any result byte that cannot be stored is a protocol error.
    assign drop     = bus.fc_out_valid && !cap_ok;
    // Same-cycle capture is counted before the end-of-pass check.
    assign out_cnt_nx = out_cnt + {{(OW-1){1'b0}}, cap_ok};
    assign count_bad  = (state == S_RUN) && bus.fc_done && (out_cnt_nx != NN_C);
    assign case_nx  = case_idx + 1'b1;
    assign in_addr  = IW'(32'(case_idx) * 32'(NUM_INPUTS) + 32'(in_ptr));
    assign res_addr = RW'(32'(case_idx) * 32'(NUM_NEURONS) + 32'(out_cnt));
    assign rd_in_range = 32'(bus.rd_addr) < 32'(RES_DEPTH);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.run) state_nx = (bus.num_cases == '0) ? S_FIN : S_START;
            S_START: state_nx = S_RUN;
            S_RUN:   if (bus.fc_done) state_nx = S_GAP;
            S_GAP:   if (gap_cnt == GAP_LAST) state_nx = (case_nx == n_q) ? S_FIN : S_START;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            n_q          <= '0;
            case_idx     <= '0;
            ld_ptr       <= '0;
            in_ptr       <= '0;
            out_cnt      <= '0;
            gap_cnt      <= '0;
            busy_q       <= 1'b0;
            batch_done_q <= 1'b0;
            err_q        <= 1'b0;
            fc_start_q   <= 1'b0;
            fc_data_in_q <= '0;
            rd_data_q    <= '0;
        end else begin
            state <= state_nx;
            // Registered from next state so the pulse coincides with START.
            fc_start_q   <= (state_nx == S_START);
            // Done pulse lands as FIN hands back to IDLE, together with busy=0.
            batch_done_q <= (state == S_FIN);

            if (run_acc) begin
                n_q      <= (bus.num_cases > MAX_C) ? MAX_C : bus.num_cases;
                case_idx <= '0;
                ld_ptr   <= '0;
                busy_q   <= 1'b1;
            end else if (ld_acc) begin
                ld_ptr <= (ld_ptr == LD_LAST) ? '0 : ld_ptr + 1'b1;
            end

            if (state == S_FIN) busy_q <= 1'b0;

            if (state == S_START) begin
                in_ptr  <= '0;
                out_cnt <= '0;
            end

            if ((state == S_RUN) && bus.fc_input_req) begin
                fc_data_in_q <= in_buf[in_addr];
                in_ptr       <= (in_ptr == IN_LAST) ? '0 : in_ptr + 1'b1;
            end

            if (cap_ok) out_cnt <= out_cnt_nx;

            if ((state == S_RUN) && bus.fc_done) gap_cnt <= '0;
            if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
                if (gap_cnt == GAP_LAST) case_idx <= case_nx;
            end

            if (run_acc) err_q <= 1'b0;
            if (drop || count_bad) err_q <= 1'b1;

            rd_data_q <= rd_in_range ? res_buf[bus.rd_addr] : '0;
        end
    end

    // Buffer storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (ld_acc) in_buf[ld_ptr] <= bus.ld_data;
        if (cap_ok) res_buf[res_addr] <= bus.fc_data_out;
    end

    assign bus.ld_ready   = (state == S_IDLE);
    assign bus.busy       = busy_q;
    assign bus.batch_done = batch_done_q;
    assign bus.err        = err_q;
    assign bus.fc_start   = fc_start_q;
    assign bus.fc_data_in = fc_data_in_q;
    assign bus.rd_data    = rd_data_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_fc_batch_sequencer.sv
module tb_fc_batch_sequencer;
    localparam int NN    = 10;
    localparam int NI    = 4;
    localparam int MC    = 8;
    localparam int GAP   = 2;
    localparam int IN_D  = MC * NI;
    localparam int RES_D = MC * NN;
    localparam int CW    = 4;
    localparam int RW    = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic [2:0] dbg_state;
    always #5 clk = ~clk;

    fc_batch_sequencer_if #(.NUM_NEURONS(NN), .MAX_CASES(MC)) bus ();

    fc_batch_sequencer #(
        .NUM_NEURONS(NN), .NUM_INPUTS(NI), .MAX_CASES(MC), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .dbg_state(dbg_state)
    );

    // ---------------- reference model ----------------
    logic [7:0] in_model  [IN_D];
    logic [7:0] res_model [RES_D];
    bit         res_known [RES_D];
    int         ld_ptr_m;
    int         checks;
    int         errors;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ld_valid     = 1'b0;
        bus.ld_data      = '0;
        bus.run          = 1'b0;
        bus.num_cases    = '0;
        bus.fc_input_req = 1'b0;
        bus.fc_out_valid = 1'b0;
        bus.fc_data_out  = '0;
        bus.fc_done      = 1'b0;
        bus.rd_addr      = '0;
    endtask

    task automatic load_byte(input logic [7:0] b);
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        step();
        bus.ld_valid = 1'b0;
        in_model[ld_ptr_m] = b;
        ld_ptr_m = (ld_ptr_m + 1) % IN_D;
    endtask

    task automatic pulse_run(input int nc);
        bus.run       = 1'b1;
        bus.num_cases = CW'(nc);
        ld_ptr_m      = 0;
    endtask

    // which=0: fc_start, which=1: batch_done. Counts cycles until seen.
    task automatic wait_for(input int which, output int cycles, output int strays);
        bit seen;
        seen = 1'b0;
        cycles = 0;
        strays = 0;
        while (!seen && cycles < 40) begin
            step();
            cycles++;
            bus.run = 1'b0; bus.fc_done = 1'b0; bus.fc_out_valid = 1'b0;
            bus.fc_input_req = 1'b0; bus.ld_valid = 1'b0;
            if (which == 0) seen = bus.fc_start;
            else begin
                seen = bus.batch_done;
                if (bus.fc_start) strays++;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_timeout which=%0d got none after %0d cycles, required an event", which, cycles);
        end
    endtask

    // Behaves as fc_layer for one pass; entered in the cycle fc_start is high.
    task automatic fc_pass(input int c, input int nouts, input bit dwl,
                           input bit rand_vals, input bit inject);
        logic [7:0] last, exp_v, v;
        int inj_k;
        step();
        checks++;
        if (bus.fc_start !== 1'b0) begin
            errors++; $display("FAIL fc_start_width case=%0d got %b required 0", c, bus.fc_start);
        end
        inj_k = inject ? $urandom_range(0, NI*NN-1) : -1;
        last = bus.fc_data_in;
        for (int k = 0; k < NI*NN; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                step();
                checks++;
                if (bus.fc_data_in !== last) begin
                    errors++; $display("FAIL fc_data_in_hold case=%0d got %h required %h", c, bus.fc_data_in, last);
                end
            end
            bus.fc_input_req = 1'b1;
            if (k == inj_k) begin
                bus.run = 1'b1; bus.num_cases = CW'(3);
                bus.ld_valid = 1'b1; bus.ld_data = 8'h5A;
                checks++;
                if (bus.ld_ready !== 1'b0) begin
                    errors++; $display("FAIL ld_ready_in_run got %b required 0", bus.ld_ready);
                end
            end
            step();
            bus.fc_input_req = 1'b0; bus.run = 1'b0; bus.ld_valid = 1'b0;
            exp_v = in_model[c*NI + k%NI];
            checks++;
            if (bus.fc_data_in !== exp_v) begin
                errors++; $display("FAIL fc_data_in case=%0d req=%0d got %h required %h", c, k, bus.fc_data_in, exp_v);
            end
            last = exp_v;
        end
        for (int j = 0; j < nouts; j++) begin
            v = rand_vals ? 8'($urandom) : 8'(c*16 + j);
            bus.fc_out_valid = 1'b1;
            bus.fc_data_out  = v;
            if (j < NN) begin
                res_model[c*NN + j] = v;
                res_known[c*NN + j] = 1'b1;
            end
            if (j == nouts-1 && dwl) bus.fc_done = 1'b1;
            else begin
                step();
                bus.fc_out_valid = 1'b0;
            end
        end
        if (!dwl) bus.fc_done = 1'b1;
    endtask

    task automatic run_batch(input int nc, input bit rand_vals, input int bad_case, input bit inject);
        int n, cyc, strays;
        bit exp_err;
        n = (nc > MC) ? MC : nc;
        exp_err = (bad_case >= 0) && (bad_case < n);
        pulse_run(nc);
        for (int c = 0; c < n; c++) begin
            wait_for(0, cyc, strays);
            checks++;
            if (cyc != ((c == 0) ? 1 : GAP+1)) begin
                errors++; $display("FAIL start_latency case=%0d got %0d required %0d", c, cyc, (c == 0) ? 1 : GAP+1);
            end
            if (c == 0) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
                    errors++; $display("FAIL run_accept busy=%b err=%b required busy=1 err=0", bus.busy, bus.err);
                end
            end
            fc_pass(c, (c == bad_case) ? NN+1 : NN, 1'($urandom_range(0, 1)), rand_vals, inject && c == 1);
        end
        wait_for(1, cyc, strays);
        checks++;
        if (cyc != GAP+2) begin
            errors++; $display("FAIL done_latency got %0d required %0d", cyc, GAP+2);
        end
        checks++;
        if (strays != 0) begin
            errors++; $display("FAIL extra_start got %0d required 0", strays);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL busy_at_done got %b required 0", bus.busy);
        end
        checks++;
        if (bus.err !== exp_err) begin
            errors++; $display("FAIL err_at_done got %b required %b", bus.err, exp_err);
        end
        step();
        checks++;
        if (bus.batch_done !== 1'b0) begin
            errors++; $display("FAIL batch_done_width got %b required 0", bus.batch_done);
        end
    endtask

    task automatic check_results();
        logic [7:0] exp_v;
        for (int a = 0; a < (1 << RW); a++) begin
            bus.rd_addr = RW'(a);
            step();
            if (a >= RES_D || res_known[a]) begin
                exp_v = (a >= RES_D) ? 8'h00 : res_model[a];
                checks++;
                if (bus.rd_data !== exp_v) begin
                    errors++; $display("FAIL rd_data addr=%0d got %h required %h", a, bus.rd_data, exp_v);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.batch_done !== 1'b0 || bus.err !== 1'b0 || bus.fc_start !== 1'b0) begin
            errors++; $display("FAIL reset_flags busy=%b done=%b err=%b start=%b required all 0",
                               bus.busy, bus.batch_done, bus.err, bus.fc_start);
        end
        checks++;
        if (bus.fc_data_in !== 8'h00 || bus.rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_data fc_data_in=%h rd_data=%h required 00 00", bus.fc_data_in, bus.rd_data);
        end
        checks++;
        if (bus.ld_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ld_ready got %b required 1", bus.ld_ready);
        end
        rst = 1'b0;
        ld_ptr_m = 0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 20; i++) begin
            if (i >= 8 && i < 12) load_byte(8'(i - 7));   // vector 2 = 01,02,03,04
            else load_byte(8'($urandom));
        end
        run_batch(5, 1'b0, -1, 1'b0);
        bus.rd_addr = RW'(22);
        step();
        checks++;
        if (bus.rd_data !== 8'h22) begin
            errors++; $display("FAIL rd_case2_neuron2 got %h required 22", bus.rd_data);
        end
        check_results();
    endtask

    task automatic test_zero_cases();
        pulse_run(0);
        step();
        bus.run = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.batch_done !== 1'b0 || bus.fc_start !== 1'b0) begin
            errors++; $display("FAIL zero_c1 busy=%b done=%b start=%b required 1 0 0", bus.busy, bus.batch_done, bus.fc_start);
        end
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.batch_done !== 1'b1 || bus.fc_start !== 1'b0 || bus.err !== 1'b0) begin
            errors++; $display("FAIL zero_c2 busy=%b done=%b start=%b err=%b required 0 1 0 0",
                               bus.busy, bus.batch_done, bus.fc_start, bus.err);
        end
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.batch_done !== 1'b0) begin
            errors++; $display("FAIL zero_c3 busy=%b done=%b required 0 0", bus.busy, bus.batch_done);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3*NI; i++) load_byte(8'($urandom));
        run_batch(3, 1'b1, 1, 1'b0);
        check_results();
        run_batch(1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_ignore_mid_batch();
        for (int i = 0; i < 3*NI; i++) load_byte(8'($urandom));
        run_batch(3, 1'b1, -1, 1'b1);
        check_results();
        for (int i = 0; i < NI; i++) load_byte(8'($urandom));
        run_batch(1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_abort();
        int cyc, strays, seen_done;
        logic [7:0] exp_v;
        for (int i = 0; i < 4*NI; i++) load_byte(8'($urandom));
        pulse_run(4);
        for (int c = 0; c < 2; c++) begin
            wait_for(0, cyc, strays);
            fc_pass(c, NN, 1'b0, 1'b1, 1'b0);
        end
        wait_for(0, cyc, strays);
        step();
        for (int k = 0; k < 3; k++) begin
            bus.fc_input_req = 1'b1;
            step();
            bus.fc_input_req = 1'b0;
            exp_v = in_model[2*NI + k];
            checks++;
            if (bus.fc_data_in !== exp_v) begin
                errors++; $display("FAIL abort_pre_data req=%0d got %h required %h", k, bus.fc_data_in, exp_v);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        ld_ptr_m = 0;
        checks++;
        if (bus.busy !== 1'b0 || bus.fc_start !== 1'b0 || bus.batch_done !== 1'b0 || bus.ld_ready !== 1'b1) begin
            errors++; $display("FAIL abort_state busy=%b start=%b done=%b ld_ready=%b required 0 0 0 1",
                               bus.busy, bus.fc_start, bus.batch_done, bus.ld_ready);
        end
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.batch_done) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++; $display("FAIL abort_no_done got %0d pulses required 0", seen_done);
        end
        run_batch(2, 1'b1, -1, 1'b0);
    endtask

    task automatic test_clamp_wrap();
        for (int i = 0; i < IN_D + NI; i++) load_byte(8'($urandom));
        run_batch(12, 1'b1, -1, 1'b0);
        check_results();
    endtask

    // ---------------- main ----------------
    initial begin
        checks = 0;
        errors = 0;
        ld_ptr_m = 0;
        for (int i = 0; i < RES_D; i++) res_known[i] = 1'b0;
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_basic();
        test_zero_cases();
        test_overflow();
        test_ignore_mid_batch();
        test_abort();
        test_clamp_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
